// File: rtl/delta_mod_pkg.sv
// Shared definitions for the delta-modulation link (encoder and demodulator).
package delta_mod_pkg;

    // Spike encoding: bit0 = up, bit1 = down.
    localparam logic [1:0] SPIKE_NONE    = 2'b00;
    localparam logic [1:0] SPIKE_UP      = 2'b01;
    localparam logic [1:0] SPIKE_DOWN    = 2'b10;
    localparam logic [1:0] SPIKE_ILLEGAL = 2'b11;

    localparam int unsigned ERR_CNT_W = 8;

    typedef enum logic {
        WAIT_SYNC = 1'b0,
        TRACK     = 1'b1
    } state_e;

endpackage

// File: rtl/delta_demodulator_if.sv
// Spike-in / sample-out handshake bundle for the delta demodulator.
// master = upstream spike source plus downstream sample sink; slave = demodulator.
interface delta_demodulator_if #(
    parameter int unsigned W = 4
) ();
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   spike;
    logic [W-1:0] threshold;
    logic         load;
    logic [W-1:0] load_value;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_sat;

    modport master (
        output in_valid, spike, threshold, load, load_value, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, spike, threshold, load, load_value, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/delta_step_sat.sv
// Combinational saturating step: acc +/- threshold clipped to [0, 2^W-1].
// Non-up/down spikes pass acc through unchanged with no saturation flag.
module delta_step_sat
    import delta_mod_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] acc_i,
    input  logic [W-1:0] thresh_i,
    input  logic [1:0]   spike_i,
    output logic [W-1:0] acc_o,
    output logic         sat_o
);
    logic [W:0] sum;
    logic [W:0] diff;

    assign sum  = {1'b0, acc_i} + {1'b0, thresh_i};
    assign diff = {1'b0, acc_i} - {1'b0, thresh_i};

    // Carry out of the sum means overflow; borrow in the difference means underflow.
    always_comb begin
        acc_o = acc_i;
        sat_o = 1'b0;
        case (spike_i)
            SPIKE_UP: begin
                if (sum[W]) begin
                    acc_o = '1;
                    sat_o = 1'b1;
                end else begin
                    acc_o = sum[W-1:0];
                end
            end
            SPIKE_DOWN: begin
                if (diff[W]) begin
                    acc_o = '0;
                    sat_o = 1'b1;
                end else begin
                    acc_o = diff[W-1:0];
                end
            end
            default: begin
                acc_o = acc_i;
                sat_o = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/delta_demodulator.sv
// Delta-modulation receiver: rebuilds the sample stream from up/down spikes.
// Optional macro DELTA_DEMOD_LEAK_EN: after LEAK_IDLE consecutive idle beats in
// TRACK, the accumulator drifts one LSB toward midscale.
module delta_demodulator
    import delta_mod_pkg::*;
#(
    parameter int unsigned W         = 4,
    parameter int unsigned AUTO_SYNC = 0,
    parameter int unsigned LEAK_IDLE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    delta_demodulator_if.slave   link,
    output logic [ERR_CNT_W-1:0] err_count_o,
    output logic                 synced_o
);
    localparam logic [W-1:0] MidScale   = W'(1) << (W - 1);
    localparam state_e       ResetState = (AUTO_SYNC != 0) ? TRACK : WAIT_SYNC;
    localparam logic [W-1:0] ResetAcc   = (AUTO_SYNC != 0) ? MidScale : '0;

    if (LEAK_IDLE == 0) begin : g_bad_leak_idle
        $error("LEAK_IDLE must be nonzero");
    end

    state_e               state_q, state_d;
    logic [W-1:0]         acc_q, acc_d;
    logic                 out_valid_q, out_valid_d;
    logic [W-1:0]         out_data_q, out_data_d;
    logic                 out_sat_q, out_sat_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;

    logic                 accept;
    logic [W-1:0]         step_acc;
    logic                 step_sat;

`ifdef DELTA_DEMOD_LEAK_EN
    localparam int unsigned IdleW = $clog2(LEAK_IDLE + 1);
    logic [IdleW-1:0] idle_q, idle_d;
`endif

    // Single output register: accept whenever it is empty or draining this cycle.
    assign link.in_ready  = !out_valid_q || link.out_ready;
    assign accept         = link.in_valid && link.in_ready;
    assign link.out_valid = out_valid_q;
    assign link.out_data  = out_data_q;
    assign link.out_sat   = out_sat_q;
    assign err_count_o    = err_q;
    assign synced_o       = (state_q == TRACK);

    delta_step_sat #(
        .W(W)
    ) u_step (
        .acc_i   (acc_q),
        .thresh_i(link.threshold),
        .spike_i (link.spike),
        .acc_o   (step_acc),
        .sat_o   (step_sat)
    );

    // Next-state: FSM, accumulator update, output register and error counter.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q && !link.out_ready;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        err_d       = err_q;
`ifdef DELTA_DEMOD_LEAK_EN
        idle_d      = idle_q;
`endif
        if (accept) begin
            if (link.load) begin
                // Load wins over any spike, including an illegal one.
                state_d     = TRACK;
                acc_d       = link.load_value;
                out_data_d  = link.load_value;
                out_sat_d   = 1'b0;
                out_valid_d = 1'b1;
`ifdef DELTA_DEMOD_LEAK_EN
                idle_d      = '0;
`endif
            end else if (link.spike == SPIKE_ILLEGAL) begin
                if (err_q != '1) begin
                    err_d = err_q + ERR_CNT_W'(1);
                end
                if (state_q == TRACK) begin
                    out_data_d  = acc_q;
                    out_sat_d   = 1'b0;
                    out_valid_d = 1'b1;
                end
`ifdef DELTA_DEMOD_LEAK_EN
                idle_d = '0;
`endif
            end else if (state_q == TRACK) begin
                acc_d       = step_acc;
                out_data_d  = step_acc;
                out_sat_d   = step_sat;
                out_valid_d = 1'b1;
`ifdef DELTA_DEMOD_LEAK_EN
                if (link.spike == SPIKE_NONE) begin
                    if (idle_q == IdleW'(LEAK_IDLE - 1)) begin
                        idle_d = '0;
                        if (acc_q < MidScale) begin
                            acc_d = acc_q + W'(1);
                        end else if (acc_q > MidScale) begin
                            acc_d = acc_q - W'(1);
                        end
                        out_data_d = acc_d;
                    end else begin
                        idle_d = idle_q + IdleW'(1);
                    end
                end else begin
                    idle_d = '0;
                end
`endif
            end
            // Non-load, legal beats in WAIT_SYNC are accepted and dropped.
        end
    end

    // State registers with synchronous reset; reset discards any pending sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ResetState;
            acc_q       <= ResetAcc;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            err_q       <= '0;
`ifdef DELTA_DEMOD_LEAK_EN
            idle_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            err_q       <= err_d;
`ifdef DELTA_DEMOD_LEAK_EN
            idle_q      <= idle_d;
`endif
        end
    end
endmodule

// File: tb/tb_delta_demodulator.sv
// Directed self-checking bench for delta_demodulator (W=4, AUTO_SYNC=0).
module tb_delta_demodulator;
    import delta_mod_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] err_count;
    logic       synced;
    int         checks = 0;
    int         errors = 0;

    delta_demodulator_if #(.W(4)) bus ();

    delta_demodulator #(
        .W        (4),
        .AUTO_SYNC(0),
        .LEAK_IDLE(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .link       (bus.slave),
        .err_count_o(err_count),
        .synced_o   (synced)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one beat, then return 1 time unit after the capturing edge.
    task automatic step(input logic ld, input logic [1:0] sp, input logic [3:0] th,
                        input logic [3:0] lv);
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.load       = ld;
        bus.spike      = sp;
        bus.threshold  = th;
        bus.load_value = lv;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.load       = 1'b0;
        bus.spike      = SPIKE_NONE;
        bus.threshold  = '0;
        bus.load_value = '0;
        bus.out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_sat", bus.out_sat, 0);
        check("rst_err", err_count, 0);
        check("rst_synced", synced, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", bus.in_ready, 1);

        // WAIT_SYNC: non-load beats dropped
        step(0, SPIKE_UP, 3, 0);
        check("ws_up1_valid", bus.out_valid, 0);
        check("ws_up1_synced", synced, 0);
        step(0, SPIKE_UP, 3, 0);
        check("ws_up2_valid", bus.out_valid, 0);
        step(0, SPIKE_ILLEGAL, 3, 0);
        check("ws_ill_valid", bus.out_valid, 0);
        check("ws_ill_err", err_count, 1);

        step(1, SPIKE_NONE, 3, 5);
        check("load5_valid", bus.out_valid, 1);
        check("load5_data", bus.out_data, 5);
        check("load5_synced", synced, 1);
        check("load5_sat", bus.out_sat, 0);

        // Tracking, threshold 4
        step(0, SPIKE_UP, 4, 0);   check("t_up_9", bus.out_data, 9);
        step(0, SPIKE_UP, 4, 0);   check("t_up_13", bus.out_data, 13);
        check("t_up_13_sat", bus.out_sat, 0);
        step(0, SPIKE_DOWN, 4, 0); check("t_dn_9", bus.out_data, 9);
        step(0, SPIKE_DOWN, 4, 0); check("t_dn_5", bus.out_data, 5);
        step(0, SPIKE_DOWN, 4, 0); check("t_dn_1", bus.out_data, 1);
        check("t_dn_1_sat", bus.out_sat, 0);
        check("t_dn_1_valid", bus.out_valid, 1);

        // Saturation at both ends
        step(1, SPIKE_NONE, 0, 14);
        step(0, SPIKE_UP, 3, 0);
        check("sat_hi_data", bus.out_data, 15);
        check("sat_hi_flag", bus.out_sat, 1);
        step(1, SPIKE_NONE, 0, 2);
        check("load2_sat", bus.out_sat, 0);
        step(0, SPIKE_DOWN, 3, 0);
        check("sat_lo_data", bus.out_data, 0);
        check("sat_lo_flag", bus.out_sat, 1);

        // Illegal spikes in TRACK
        step(1, SPIKE_NONE, 0, 7);
        step(0, SPIKE_ILLEGAL, 3, 0);
        check("ill1_data", bus.out_data, 7);
        check("ill1_valid", bus.out_valid, 1);
        step(0, SPIKE_ILLEGAL, 3, 0);
        check("ill2_data", bus.out_data, 7);
        step(0, SPIKE_ILLEGAL, 3, 0);
        check("ill3_data", bus.out_data, 7);
        check("ill3_err", err_count, 4);
        step(1, SPIKE_ILLEGAL, 3, 7);
        check("load_ill_err", err_count, 4);
        check("load_ill_data", bus.out_data, 7);

        // Zero threshold and idle spike
        step(0, SPIKE_UP, 0, 0);
        check("th0_data", bus.out_data, 7);
        check("th0_sat", bus.out_sat, 0);
        step(0, SPIKE_NONE, 5, 0);
        check("none_data", bus.out_data, 7);
        check("none_valid", bus.out_valid, 1);

        for (int i = 0; i < 300; i++) begin
            step(0, SPIKE_ILLEGAL, 1, 0);
        end
        check("err_saturate", err_count, 255);
        check("err_sat_data", bus.out_data, 7);

        // Backpressure
        idle();
        check("bp_drain_valid", bus.out_valid, 0);
        bus.out_ready = 1'b0;
        step(0, SPIKE_UP, 1, 0);
        check("bp_first_data", bus.out_data, 8);
        check("bp_first_valid", bus.out_valid, 1);
        check("bp_in_ready", bus.in_ready, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, SPIKE_UP, 1, 0);
            check("bp_hold_data", bus.out_data, 8);
            check("bp_hold_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        step(0, SPIKE_UP, 1, 0);
        check("bp_rel_9", bus.out_data, 9);
        step(0, SPIKE_UP, 1, 0);
        check("bp_rel_10", bus.out_data, 10);
        idle();
        check("bp_end_valid", bus.out_valid, 0);

        // Reset during a stall
        bus.out_ready = 1'b0;
        step(0, SPIKE_UP, 1, 0);
        check("rs_pend_data", bus.out_data, 11);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        @(posedge clk);
        #1;
        check("rs_valid", bus.out_valid, 0);
        check("rs_data", bus.out_data, 0);
        check("rs_synced", synced, 0);
        check("rs_err", err_count, 0);
        @(negedge clk);
        rst           = 1'b0;
        bus.out_ready = 1'b1;

        step(1, SPIKE_NONE, 0, 12);
        check("lk_load", bus.out_data, 12);
`ifdef DELTA_DEMOD_LEAK_EN
        for (int i = 1; i <= 16; i++) begin
            step(0, SPIKE_NONE, 3, 0);
            check("lk_run", bus.out_data, (i < 8) ? 12 : (i < 16) ? 11 : 10);
        end
        step(1, SPIKE_NONE, 0, 12);
        for (int i = 0; i < 4; i++) begin
            step(0, SPIKE_NONE, 3, 0);
            check("lk_pre", bus.out_data, 12);
        end
        step(0, SPIKE_UP, 0, 0);
        check("lk_up", bus.out_data, 12);
        for (int i = 1; i <= 8; i++) begin
            step(0, SPIKE_NONE, 3, 0);
            check("lk_restart", bus.out_data, (i < 8) ? 12 : 11);
        end
`else
        for (int i = 0; i < 16; i++) begin
            step(0, SPIKE_NONE, 3, 0);
            check("noleak_hold", bus.out_data, 12);
        end
`endif
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
